// File: rtl/packet_deserializer_if.sv
// rtl/packet_deserializer_if.sv - frame output valid/ready bundle for packet_deserializer
// master side presents frames, slave side consumes them.
interface packet_deserializer_if #(
   parameter int PACKET_SIZE = 192
);
   logic [PACKET_SIZE-1:0] packet_out;
   logic                   packet_valid;
   logic                   packet_ready;

   modport master (
      output packet_out,
      output packet_valid,
      input  packet_ready
   );

   modport slave (
      input  packet_out,
      input  packet_valid,
      output packet_ready
   );
endinterface

// File: rtl/packet_deserializer.sv
// rtl/packet_deserializer.sv - sync-hunting bit-serial frame assembler
// Hunts SYNC_PATTERN, shifts in a PACKET_SIZE frame MSB-first, holds it in a one-deep output buffer.
module packet_deserializer #(
   parameter int                    PACKET_SIZE  = 192,
   parameter int                    SYNC_WIDTH   = 8,
   parameter logic [SYNC_WIDTH-1:0] SYNC_PATTERN = 8'hFF,
   parameter int                    GAP_TIMEOUT  = 4096
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_bit_in,
   input  logic                   i_bit_valid,
   packet_deserializer_if.master  o_pkt,
   output logic                   o_busy,
   output logic                   o_overrun,
   output logic                   o_sync_lost
);

   localparam int CNT_W = $clog2(PACKET_SIZE + 1);
   localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PACKET_SIZE - 1);
   localparam logic [CNT_W-1:0] CNT_SYNC = CNT_W'(SYNC_WIDTH);
   localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP_TIMEOUT);

   typedef enum logic [0:0] {
      ST_HUNT    = 1'b0,
      ST_COLLECT = 1'b1
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;

   logic [SYNC_WIDTH-1:0]  r_hunt_sr;
   logic [PACKET_SIZE-1:0] r_frame_sr;
   logic [CNT_W-1:0]       r_count;
   logic [GAP_W-1:0]       r_gap;
   logic                   r_sync_lost;

   logic [PACKET_SIZE-1:0] r_pkt_out;
   logic                   r_pkt_valid;
   logic                   r_overrun;

   logic [SYNC_WIDTH-1:0]  w_hunt_next;
   logic [PACKET_SIZE-1:0] w_frame_next;
   logic [GAP_W-1:0]       w_gap_inc;
   logic                   w_lock;
   logic                   w_complete;
   logic                   w_timeout;
   logic                   w_buf_free;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_HUNT;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_hunt_next  = {r_hunt_sr[SYNC_WIDTH-2:0], i_bit_in};
      w_frame_next = {r_frame_sr[PACKET_SIZE-2:0], i_bit_in};
      w_gap_inc    = r_gap + GAP_W'(1);
      w_state_next = r_state;
      w_lock       = 1'b0;
      w_complete   = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         ST_HUNT: begin
            if (i_bit_valid && (w_hunt_next == SYNC_PATTERN)) begin
               w_lock       = 1'b1;
               w_state_next = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (i_bit_valid) begin
               if (r_count == CNT_LAST) begin
                  w_complete   = 1'b1;
                  w_state_next = ST_HUNT;
               end
            end else if (w_gap_inc == GAP_MAX) begin
               w_timeout    = 1'b1;
               w_state_next = ST_HUNT;
            end
         end
         default: begin
            w_state_next = ST_HUNT;
         end
      endcase
   end

   // Leaving COLLECT clears hunt_sr so a new lock never borrows bits from the previous frame.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_hunt_sr   <= '0;
         r_frame_sr  <= '0;
         r_count     <= '0;
         r_gap       <= '0;
         r_sync_lost <= 1'b0;
      end else begin
         r_sync_lost <= w_timeout;
         case (r_state)
            ST_HUNT: begin
               if (i_bit_valid) begin
                  r_hunt_sr <= w_hunt_next;
                  if (w_lock) begin
                     r_frame_sr <= PACKET_SIZE'(SYNC_PATTERN);
                     r_count    <= CNT_SYNC;
                     r_gap      <= '0;
                  end
               end
            end
            ST_COLLECT: begin
               if (i_bit_valid) begin
                  r_frame_sr <= w_frame_next;
                  r_count    <= r_count + CNT_W'(1);
                  r_gap      <= '0;
                  if (w_complete) begin
                     r_hunt_sr <= '0;
                  end
               end else begin
                  r_gap <= w_gap_inc;
                  if (w_timeout) begin
                     r_hunt_sr <= '0;
                  end
               end
            end
            default: begin
               r_hunt_sr <= '0;
            end
         endcase
      end
   end

   // A consumer handshake in the completion cycle frees the buffer for the new frame.
   assign w_buf_free = !r_pkt_valid || o_pkt.packet_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pkt_out   <= '0;
         r_pkt_valid <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         if (w_complete) begin
            if (w_buf_free) begin
               r_pkt_out   <= w_frame_next;
               r_pkt_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_pkt_valid && o_pkt.packet_ready) begin
            r_pkt_valid <= 1'b0;
         end
      end
   end

   assign o_pkt.packet_out   = r_pkt_out;
   assign o_pkt.packet_valid = r_pkt_valid;
   assign o_busy             = (r_state == ST_COLLECT);
   assign o_overrun          = r_overrun;
   assign o_sync_lost        = r_sync_lost;

endmodule

// File: tb/tb_packet_deserializer.sv
// tb/tb_packet_deserializer.sv - self-checking bench for packet_deserializer
// Directed phases plus random noise/frame streams checked against a run-length frame model.
module tb_packet_deserializer;

   localparam int PS  = 192;
   localparam int SW  = 8;
   localparam int GAP = 4096;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic bit_in = 1'b0;
   logic bit_valid = 1'b0;
   logic busy;
   logic overrun;
   logic sync_lost;

   packet_deserializer_if #(.PACKET_SIZE(PS)) pkt_if ();

   packet_deserializer #(
      .PACKET_SIZE (PS),
      .SYNC_WIDTH  (SW),
      .SYNC_PATTERN(8'hFF),
      .GAP_TIMEOUT (GAP)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_bit_in   (bit_in),
      .i_bit_valid(bit_valid),
      .o_pkt      (pkt_if.master),
      .o_busy     (busy),
      .o_overrun  (overrun),
      .o_sync_lost(sync_lost)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   bit            stream_q[$];
   logic [PS-1:0] exp_q[$];
   logic [PS-1:0] got_q[$];
   logic          busy_q[$];

   int ov_cnt = 0;
   int sl_cnt = 0;
   int pv_rise = 0;
   int got_base = 0;
   int ov_base = 0;
   int sl_base = 0;
   int pv_base = 0;

   logic          lat_valid;
   logic [PS-1:0] lat_out;
   logic          prev_v = 1'b0;
   logic          prev_r = 1'b0;
   logic [PS-1:0] prev_out = '0;

   task automatic chk(input string tag, input logic [PS-1:0] obs, input logic [PS-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (pkt_if.packet_valid && pkt_if.packet_ready) got_q.push_back(pkt_if.packet_out);
         if (overrun) ov_cnt++;
         if (sync_lost) sl_cnt++;
         if (pkt_if.packet_valid && !prev_v) pv_rise++;
         if (prev_v && !prev_r && pkt_if.packet_valid) chk("hold_stable", pkt_if.packet_out, prev_out);
      end
      prev_v   = pkt_if.packet_valid;
      prev_r   = pkt_if.packet_ready;
      prev_out = pkt_if.packet_out;
   end

   // Frames start at the first run of SW ones; the SW+... bits from there form the frame.
   function automatic void run_model();
      int run;
      int i;
      int s;
      logic [PS-1:0] fr;
      exp_q.delete();
      run = 0;
      i = 0;
      while (i < stream_q.size()) begin
         run = stream_q[i] ? run + 1 : 0;
         if (run == SW) begin
            s = i - SW + 1;
            if (s + PS <= stream_q.size()) begin
               for (int k = 0; k < PS; k++) fr[PS-1-k] = stream_q[s+k];
               exp_q.push_back(fr);
            end
            i = s + PS;
            run = 0;
         end else begin
            i++;
         end
      end
   endfunction

   function automatic logic [PS-1:0] make_frame();
      logic [PS-1:0] f;
      for (int k = 0; k < PS / 32; k++) f[k*32 +: 32] = $urandom;
      f[PS-1 -: 8] = 8'hFF;
      return f;
   endfunction

   task automatic strobe(input logic b, input logic pulse_ready);
      bit_in = b;
      bit_valid = 1'b1;
      stream_q.push_back(b);
      if (pulse_ready) pkt_if.packet_ready = 1'b1;
      @(posedge clk); #1;
      bit_valid = 1'b0;
      if (pulse_ready) pkt_if.packet_ready = 1'b0;
      lat_valid = pkt_if.packet_valid;
      lat_out = pkt_if.packet_out;
      busy_q.push_back(busy);
      repeat (3) begin @(posedge clk); #1; end
   endtask

   task automatic send_frame(input logic [PS-1:0] f, input int nbits, input logic pulse_last);
      for (int i = 0; i < nbits; i++) strobe(f[PS-1-i], pulse_last && (i == nbits - 1));
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) strobe(b[i], 1'b0);
   endtask

   task automatic rebase();
      stream_q.delete();
      busy_q.delete();
      got_base = got_q.size();
      ov_base = ov_cnt;
      sl_base = sl_cnt;
      pv_base = pv_rise;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bit_valid = 1'b0;
      pkt_if.packet_ready = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0;
      rebase();
   endtask

   task automatic check_model(input string tag);
      run_model();
      chk({tag, "_count"}, PS'(got_q.size() - got_base), PS'(exp_q.size()));
      foreach (exp_q[i]) begin
         if (got_base + i < got_q.size()) chk({tag, "_frame"}, got_q[got_base+i], exp_q[i]);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_valid"}, PS'(pkt_if.packet_valid), '0);
      chk({tag, "_out"}, pkt_if.packet_out, '0);
      chk({tag, "_busy"}, PS'(busy), '0);
      chk({tag, "_overrun"}, PS'(overrun), '0);
      chk({tag, "_sync_lost"}, PS'(sync_lost), '0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [PS-1:0] f;
      logic [PS-1:0] g;
      int n;
      int nb;

      pkt_if.packet_ready = 1'b0;
      rst = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      check_all_zero("reset");
      rst = 1'b0;
      rebase();

      // 1: single frame, ready held high, latency one clock after last strobe
      pkt_if.packet_ready = 1'b1;
      f = make_frame();
      f[183:168] = 16'h5468;
      f[15:0] = 16'h6521;
      send_frame(f, PS, 1'b0);
      chk("t1_latency_valid", PS'(lat_valid), PS'(1));
      chk("t1_latency_out", lat_out, f);
      chk("t1_pv_pulses", PS'(pv_rise - pv_base), PS'(1));
      check_model("t1");

      // 2: noise 0x7F 0x3C then a frame, no false lock
      do_reset();
      pkt_if.packet_ready = 1'b1;
      send_byte(8'h7F);
      send_byte(8'h3C);
      f = make_frame();
      send_frame(f, PS, 1'b0);
      nb = 0;
      for (int i = 0; i < 16; i++) nb += int'(busy_q[i]);
      chk("t2_no_false_lock", PS'(nb), '0);
      chk("t2_busy_7th_one", PS'(busy_q[22]), '0);
      chk("t2_busy_8th_one", PS'(busy_q[23]), PS'(1));
      check_model("t2");
      if (got_q.size() > got_base) chk("t2_frame", got_q[got_base], f);

      // 3: back-to-back frames with no consumer
      do_reset();
      f = make_frame();
      g = make_frame();
      send_frame(f, PS, 1'b0);
      send_frame(g, PS, 1'b0);
      chk("t3_overrun_once", PS'(ov_cnt - ov_base), PS'(1));
      chk("t3_valid_held", PS'(pkt_if.packet_valid), PS'(1));
      chk("t3_out_held", pkt_if.packet_out, f);
      pkt_if.packet_ready = 1'b1;
      @(posedge clk); #1;
      pkt_if.packet_ready = 1'b0;
      chk("t3_valid_drop", PS'(pkt_if.packet_valid), '0);
      chk("t3_got_count", PS'(got_q.size() - got_base), PS'(1));
      if (got_q.size() > got_base) chk("t3_got_frame", got_q[got_base], f);

      // 4: gap timeout after 100 bits, then a clean frame
      do_reset();
      pkt_if.packet_ready = 1'b1;
      f = make_frame();
      send_frame(f, 100, 1'b0);
      chk("t4_busy_mid", PS'(busy), PS'(1));
      n = 0;
      while (!sync_lost && n < GAP + 64) begin
         @(posedge clk); #1;
         n++;
      end
      chk("t4_sync_lost_seen", PS'(sync_lost), PS'(1));
      chk("t4_gap_time", PS'(n >= GAP - 4 && n <= GAP - 2), PS'(1));
      repeat (8) begin @(posedge clk); #1; end
      chk("t4_sync_lost_once", PS'(sl_cnt - sl_base), PS'(1));
      chk("t4_busy_after", PS'(busy), '0);
      chk("t4_no_valid", PS'(pkt_if.packet_valid), '0);
      chk("t4_no_frame", PS'(got_q.size() - got_base), '0);
      stream_q.delete();
      f = make_frame();
      send_frame(f, PS, 1'b0);
      check_model("t4");

      // 5: reset mid-frame while a frame is held
      do_reset();
      f = make_frame();
      send_frame(f, PS, 1'b0);
      g = make_frame();
      send_frame(g, 150, 1'b0);
      chk("t5_pre_valid", PS'(pkt_if.packet_valid), PS'(1));
      chk("t5_pre_busy", PS'(busy), PS'(1));
      rst = 1'b1;
      @(posedge clk); #1;
      check_all_zero("t5_rst");
      rst = 1'b0;
      rebase();
      pkt_if.packet_ready = 1'b1;
      f = make_frame();
      send_frame(f, PS, 1'b0);
      check_model("t5");

      // 6: consumer handshake coincides with a new completion
      do_reset();
      f = make_frame();
      g = make_frame();
      send_frame(f, PS, 1'b0);
      send_frame(g, PS, 1'b1);
      chk("t6_valid_stays", PS'(lat_valid), PS'(1));
      chk("t6_out_new", lat_out, g);
      chk("t6_no_overrun", PS'(ov_cnt - ov_base), '0);
      chk("t6_first_taken", PS'(got_q.size() - got_base), PS'(1));
      if (got_q.size() > got_base) chk("t6_first_frame", got_q[got_base], f);
      pkt_if.packet_ready = 1'b1;
      @(posedge clk); #1;
      pkt_if.packet_ready = 1'b0;
      chk("t6_second_taken", PS'(got_q.size() - got_base), PS'(2));
      if (got_q.size() > got_base + 1) chk("t6_second_frame", got_q[got_base+1], g);

      // 7: random noise around random frames
      for (int it = 0; it < 3; it++) begin
         do_reset();
         pkt_if.packet_ready = 1'b1;
         n = $urandom_range(4, 24);
         for (int i = 0; i < n; i++) strobe(1'($urandom), 1'b0);
         f = make_frame();
         send_frame(f, PS, 1'b0);
         for (int i = 0; i < 8; i++) strobe(1'($urandom), 1'b0);
         check_model("t7");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
